// File: rtl/spi_cmd_dec.sv
// spi_cmd_dec: turns synchronized SPI frames into register-file / OWT bus accesses.
// Define SPI_ERR_CNT_EN to add the saturating error counter output o_err_cnt.
module spi_cmd_dec #(
    parameter int                REG_AW        = 7,
    parameter int                REG_DW        = 8,
    parameter logic [REG_AW-1:0] OWT_ADDR_BASE = 7'h60,
    parameter int                MIX_ACC_GAP   = 100,
    parameter int                RACK_TO       = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frm_vld,
    input  logic [7:0]        i_frm_cmd,
    input  logic [REG_DW-1:0] i_frm_data,
    input  logic              i_frm_crc_err,
    output logic              o_spi_reg_wen,
    output logic              o_spi_reg_ren,
    output logic [REG_AW-1:0] o_spi_reg_addr,
    output logic [REG_DW-1:0] o_spi_reg_wdata,
    input  logic              i_reg_spi_rack,
    input  logic [REG_DW-1:0] i_reg_spi_rdata,
    output logic              o_spi_owt_wen,
    output logic              o_spi_owt_ren,
    output logic [REG_AW-1:0] o_spi_owt_addr,
    output logic [REG_DW-1:0] o_spi_owt_wdata,
    output logic [REG_DW-1:0] o_tx_data,
    output logic              o_tx_vld,
    output logic              o_spi_err,
`ifdef SPI_ERR_CNT_EN
    output logic [7:0]        o_err_cnt,
`endif
    input  logic              i_err_clr
);

    localparam int TO_W = (RACK_TO < 2) ? 1 : $clog2(RACK_TO);

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        WR,
        OWT_RD,
        RD_REQ,
        RD_WAIT,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_WR,
        ACC_RD
    } acc_t;

    state_t state_q;
    state_t state_d;

    logic [7:0]        cmd_q;
    logic [REG_DW-1:0] data_q;
    logic              crc_q;
    logic [15:0]       gap_q;
    acc_t              last_q;
    logic [TO_W-1:0]   to_q;

    logic [REG_AW-1:0] addr;
    logic              is_wr;
    logic              is_owt;
    acc_t              cur_acc;
    logic              gap_viol;
    logic              acc_start;
    logic              rack_hit;
    logic              to_hit;
    logic              frm_drop;
    logic              err_set;

    always_comb begin
        addr      = cmd_q[REG_AW-1:0];
        is_wr     = cmd_q[7];
        is_owt    = (addr >= OWT_ADDR_BASE);
        cur_acc   = is_wr ? ACC_WR : ACC_RD;
        gap_viol  = (last_q != ACC_NONE) && (last_q != cur_acc)
                    && (gap_q < 16'(MIX_ACC_GAP));
        acc_start = (state_q == CHK) && !crc_q && !gap_viol;
        rack_hit  = (state_q == RD_WAIT) && i_reg_spi_rack;
        // rack takes priority over a timeout expiring in the same cycle
        to_hit    = (state_q == RD_WAIT) && !i_reg_spi_rack
                    && (to_q == TO_W'(RACK_TO - 1));
        frm_drop  = i_frm_vld && (state_q != IDLE);
        err_set   = (state_q == ERR) || frm_drop;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        o_spi_reg_wen = 1'b0;
        o_spi_reg_ren = 1'b0;
        o_spi_owt_wen = 1'b0;
        o_spi_owt_ren = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_frm_vld) begin
                    state_d = CHK;
                end
            end
            CHK: begin
                if (crc_q || gap_viol) begin
                    state_d = ERR;
                end else if (is_wr) begin
                    state_d = WR;
                end else if (is_owt) begin
                    state_d = OWT_RD;
                end else begin
                    state_d = RD_REQ;
                end
            end
            WR: begin
                o_spi_owt_wen = is_owt;
                o_spi_reg_wen = !is_owt;
                state_d       = IDLE;
            end
            OWT_RD: begin
                o_spi_owt_ren = 1'b1;
                state_d       = IDLE;
            end
            RD_REQ: begin
                o_spi_reg_ren = 1'b1;
                state_d       = RD_WAIT;
            end
            RD_WAIT: begin
                o_spi_reg_ren = 1'b1;
                if (rack_hit) begin
                    state_d = IDLE;
                end else if (to_hit) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q           <= '0;
            data_q          <= '0;
            crc_q           <= 1'b0;
            gap_q           <= '1;
            last_q          <= ACC_NONE;
            to_q            <= '0;
            o_spi_reg_addr  <= '0;
            o_spi_reg_wdata <= '0;
            o_spi_owt_addr  <= '0;
            o_spi_owt_wdata <= '0;
            o_tx_data       <= '0;
            o_tx_vld        <= 1'b0;
        end else begin
            o_tx_vld <= 1'b0;

            if ((state_q == IDLE) && i_frm_vld) begin
                cmd_q  <= i_frm_cmd;
                data_q <= i_frm_data;
                crc_q  <= i_frm_crc_err;
            end

            // gap is measured from the start of the last accepted access
            if (acc_start) begin
                gap_q  <= '0;
                last_q <= cur_acc;
            end else if (gap_q != '1) begin
                gap_q <= gap_q + 16'd1;
            end

            if (acc_start) begin
                if (is_owt) begin
                    o_spi_owt_addr <= addr;
                    if (is_wr) begin
                        o_spi_owt_wdata <= data_q;
                    end
                end else begin
                    o_spi_reg_addr <= addr;
                    if (is_wr) begin
                        o_spi_reg_wdata <= data_q;
                    end
                end
            end

            if (state_q == RD_REQ) begin
                to_q <= TO_W'(1);
            end else if (state_q == RD_WAIT) begin
                to_q <= to_q + TO_W'(1);
            end

            if (rack_hit) begin
                o_tx_data <= i_reg_spi_rdata;
                o_tx_vld  <= 1'b1;
            end else if (to_hit) begin
                o_tx_data <= '1;
                o_tx_vld  <= 1'b1;
            end else if (state_q == OWT_RD) begin
                o_tx_data <= '0;
                o_tx_vld  <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_spi_err <= 1'b0;
        end else if (err_set) begin
            o_spi_err <= 1'b1;
        end else if (i_err_clr) begin
            o_spi_err <= 1'b0;
        end
    end

`ifdef SPI_ERR_CNT_EN
    logic [1:0] err_evt;
    logic [8:0] cnt_sum;

    // a dropped frame can coincide with an ERR cycle: two events at once
    always_comb begin
        err_evt = {1'b0, state_q == ERR} + {1'b0, frm_drop};
        cnt_sum = (i_err_clr ? 9'd0 : {1'b0, o_err_cnt}) + {7'd0, err_evt};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_cnt <= '0;
        end else if (i_err_clr || (err_evt != 2'd0)) begin
            o_err_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_spi_cmd_dec.sv
// tb_spi_cmd_dec: directed and randomized frames checked against a
// frame-level model of access types, gap timing and read outcomes.
`timescale 1ns/1ps
module tb_spi_cmd_dec;

    localparam int MIX_GAP = 100;
    localparam int RACK_TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frm_vld = 1'b0;
    logic [7:0] frm_cmd = 8'h00;
    logic [7:0] frm_data = 8'h00;
    logic       frm_crc_err = 1'b0;
    logic       reg_wen;
    logic       reg_ren;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_rack = 1'b0;
    logic [7:0] reg_rdata = 8'h00;
    logic       owt_wen;
    logic       owt_ren;
    logic [6:0] owt_addr;
    logic [7:0] owt_wdata;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       spi_err;
    logic       err_clr = 1'b0;
`ifdef SPI_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    spi_cmd_dec dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_frm_vld       (frm_vld),
        .i_frm_cmd       (frm_cmd),
        .i_frm_data      (frm_data),
        .i_frm_crc_err   (frm_crc_err),
        .o_spi_reg_wen   (reg_wen),
        .o_spi_reg_ren   (reg_ren),
        .o_spi_reg_addr  (reg_addr),
        .o_spi_reg_wdata (reg_wdata),
        .i_reg_spi_rack  (reg_rack),
        .i_reg_spi_rdata (reg_rdata),
        .o_spi_owt_wen   (owt_wen),
        .o_spi_owt_ren   (owt_ren),
        .o_spi_owt_addr  (owt_addr),
        .o_spi_owt_wdata (owt_wdata),
        .o_tx_data       (tx_data),
        .o_tx_vld        (tx_vld),
        .o_spi_err       (spi_err),
`ifdef SPI_ERR_CNT_EN
        .o_err_cnt       (err_cnt),
`endif
        .i_err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         reg_wen_n;
        int         reg_wen_k;
        int         owt_wen_n;
        int         owt_wen_k;
        int         owt_ren_n;
        int         ren_n;
        int         ren_k;
        int         tx_n;
        logic [7:0] tx_data;
        logic [6:0] reg_addr;
        logic [7:0] reg_wdata;
        logic [6:0] owt_addr;
        logic [7:0] owt_wdata;
        logic       err;
        logic [7:0] cnt;
    } obs_t;

    int n_chk = 0;
    int n_pass = 0;
    int prev_vld = 0;
    int last_acc = 0;
    int last_cyc = 0;

    function automatic bit model_step(input logic [7:0] cmd, input logic crc,
                                      input int vc);
        int acc;
        bit bad;
        acc = cmd[7] ? 1 : 2;
        bad = crc || (last_acc != 0 && last_acc != acc
                      && (vc - last_cyc) < MIX_GAP);
        if (!bad) begin
            last_acc = acc;
            last_cyc = vc;
        end
        return bad;
    endfunction

    task automatic wait_to(input int target);
        int n;
        n = target - cyc - 1;
        if (n < 0) n = 0;
        repeat (n) @(posedge clk);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] data,
                             input logic crc, input int dly,
                             input logic [7:0] rdata, input int win,
                             input int drop_k, output obs_t o,
                             output int vc);
        o = '{default: 0};
        o.reg_wen_k = -1;
        o.owt_wen_k = -1;
        o.ren_k = -1;
        vc = 0;
        for (int k = 0; k < win; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) vc = cyc;
            frm_vld     = (k == 0) || (k == drop_k);
            frm_cmd     = (k == drop_k) ? 8'h85 : cmd;
            frm_data    = data;
            frm_crc_err = (k == 0) ? crc : 1'b0;
            err_clr     = (k == 0);
            reg_rack    = (dly >= 0) && (k == dly + 2);
            reg_rdata   = reg_rack ? rdata : 8'($urandom);
            @(negedge clk);
            if (reg_wen) begin
                o.reg_wen_n++;
                if (o.reg_wen_k < 0) o.reg_wen_k = k;
                o.reg_addr = reg_addr;
                o.reg_wdata = reg_wdata;
            end
            if (owt_wen) begin
                o.owt_wen_n++;
                if (o.owt_wen_k < 0) o.owt_wen_k = k;
                o.owt_addr = owt_addr;
                o.owt_wdata = owt_wdata;
            end
            if (owt_ren) begin
                o.owt_ren_n++;
                o.owt_addr = owt_addr;
            end
            if (reg_ren) begin
                o.ren_n++;
                if (o.ren_k < 0) o.ren_k = k;
            end
            if (tx_vld) begin
                o.tx_n++;
                o.tx_data = tx_data;
            end
        end
        frm_vld = 1'b0;
        frm_crc_err = 1'b0;
        reg_rack = 1'b0;
        err_clr = 1'b0;
        o.err = spi_err;
`ifdef SPI_ERR_CNT_EN
        o.cnt = err_cnt;
`endif
        prev_vld = vc;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if ({reg_wen, reg_ren, owt_wen, owt_ren, tx_vld, spi_err} !== 6'b0) $display("FAIL rst_strobes got %b want 000000", {reg_wen, reg_ren, owt_wen, owt_ren, tx_vld, spi_err}); else n_pass++;
        n_chk++; if ({reg_addr, owt_addr} !== 14'h0) $display("FAIL rst_addr got %h want 0", {reg_addr, owt_addr}); else n_pass++;
        n_chk++; if ({reg_wdata, owt_wdata, tx_data} !== 24'h0) $display("FAIL rst_data got %h want 0", {reg_wdata, owt_wdata, tx_data}); else n_pass++;
`ifdef SPI_ERR_CNT_EN
        n_chk++; if (err_cnt !== 8'h00) $display("FAIL rst_cnt got %h want 00", err_cnt); else n_pass++;
`endif
        rst_n = 1'b1;
        last_acc = 0;
    endtask

    task automatic test_write();
        obs_t o;
        int vc;
        bit bad;
        run_frame(8'h85, 8'h3C, 1'b0, -1, 8'h00, 4, -1, o, vc);
        bad = model_step(8'h85, 1'b0, vc);
        n_chk++; if (o.reg_wen_n !== 1) $display("FAIL wr_wen_n got %0d want 1", o.reg_wen_n); else n_pass++;
        n_chk++; if (o.reg_wen_k !== 2) $display("FAIL wr_latency got %0d want 2", o.reg_wen_k); else n_pass++;
        n_chk++; if (o.reg_addr !== 7'h05) $display("FAIL wr_addr got %h want 05", o.reg_addr); else n_pass++;
        n_chk++; if (o.reg_wdata !== 8'h3C) $display("FAIL wr_wdata got %h want 3c", o.reg_wdata); else n_pass++;
        n_chk++; if (o.owt_wen_n !== 0) $display("FAIL wr_owt_wen got %0d want 0", o.owt_wen_n); else n_pass++;
        n_chk++; if (o.err !== bad) $display("FAIL wr_err got %b want %b", o.err, bad); else n_pass++;
    endtask

    task automatic test_read();
        obs_t o;
        int vc;
        bit bad;
        wait_to(last_cyc + 120);
        run_frame(8'h05, 8'h00, 1'b0, 3, 8'hA7, 10, -1, o, vc);
        bad = model_step(8'h05, 1'b0, vc);
        n_chk++; if (o.ren_n !== 4) $display("FAIL rd_ren_n got %0d want 4", o.ren_n); else n_pass++;
        n_chk++; if (o.ren_k !== 2) $display("FAIL rd_latency got %0d want 2", o.ren_k); else n_pass++;
        n_chk++; if (o.tx_n !== 1 || o.tx_data !== 8'hA7) $display("FAIL rd_tx got %0d/%h want 1/a7", o.tx_n, o.tx_data); else n_pass++;
        n_chk++; if (o.err !== 1'b0 || bad) $display("FAIL rd_err got %b want 0", o.err); else n_pass++;
    endtask

    task automatic test_gap();
        obs_t o;
        int vc;
        bit bad;
        wait_to(prev_vld + 150);
        run_frame(8'h85, 8'h11, 1'b0, -1, 8'h00, 4, -1, o, vc);
        bad = model_step(8'h85, 1'b0, vc);
        n_chk++; if (o.reg_wen_n !== 1) $display("FAIL gap_wr got %0d want 1", o.reg_wen_n); else n_pass++;
        wait_to(prev_vld + 20);
        run_frame(8'h05, 8'h00, 1'b0, 2, 8'h33, 6, -1, o, vc);
        bad = model_step(8'h05, 1'b0, vc);
        n_chk++; if (o.ren_n !== 0) $display("FAIL gap_ren got %0d want 0", o.ren_n); else n_pass++;
        n_chk++; if (o.err !== 1'b1) $display("FAIL gap_err got %b want 1", o.err); else n_pass++;
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        n_chk++; if (spi_err !== 1'b0) $display("FAIL err_clr got %b want 0", spi_err); else n_pass++;
    endtask

    task automatic test_timeout();
        obs_t o;
        int vc;
        bit bad;
        wait_to(prev_vld + 150);
        run_frame(8'h10, 8'h00, 1'b0, -1, 8'h00, 20, -1, o, vc);
        bad = model_step(8'h10, 1'b0, vc);
        n_chk++; if (o.ren_n !== RACK_TO) $display("FAIL to_ren_n got %0d want %0d", o.ren_n, RACK_TO); else n_pass++;
        n_chk++; if (o.tx_n !== 1 || o.tx_data !== 8'hFF) $display("FAIL to_tx got %0d/%h want 1/ff", o.tx_n, o.tx_data); else n_pass++;
        n_chk++; if (o.err !== 1'b1) $display("FAIL to_err got %b want 1", o.err); else n_pass++;
`ifdef SPI_ERR_CNT_EN
        n_chk++; if (o.cnt !== 8'd1) $display("FAIL to_cnt got %0d want 1", o.cnt); else n_pass++;
`endif
        wait_to(prev_vld + 25);
        run_frame(8'h10, 8'h00, 1'b0, RACK_TO - 1, 8'h6E, 20, -1, o, vc);
        bad = model_step(8'h10, 1'b0, vc);
        n_chk++; if (o.ren_n !== RACK_TO || o.tx_data !== 8'h6E) $display("FAIL rack_wins got %0d/%h want %0d/6e", o.ren_n, o.tx_data, RACK_TO); else n_pass++;
        n_chk++; if (o.err !== 1'b0) $display("FAIL rack_wins_err got %b want 0", o.err); else n_pass++;
    endtask

    task automatic test_owt();
        obs_t o;
        int vc;
        bit bad;
        wait_to(prev_vld + 150);
        run_frame(8'hE1, 8'h55, 1'b0, -1, 8'h00, 4, -1, o, vc);
        bad = model_step(8'hE1, 1'b0, vc);
        n_chk++; if (o.owt_wen_n !== 1 || o.owt_wen_k !== 2) $display("FAIL owt_wen got %0d@%0d want 1@2", o.owt_wen_n, o.owt_wen_k); else n_pass++;
        n_chk++; if (o.owt_addr !== 7'h61 || o.owt_wdata !== 8'h55) $display("FAIL owt_bus got %h/%h want 61/55", o.owt_addr, o.owt_wdata); else n_pass++;
        n_chk++; if (o.reg_wen_n !== 0) $display("FAIL owt_reg_wen got %0d want 0", o.reg_wen_n); else n_pass++;
        n_chk++; if (reg_addr !== 7'h10 || reg_wdata !== 8'h11) $display("FAIL reg_hold got %h/%h want 10/11", reg_addr, reg_wdata); else n_pass++;
    endtask

    task automatic test_crc();
        obs_t o;
        int vc;
        bit bad;
        wait_to(prev_vld + 30);
        run_frame(8'h85, 8'h99, 1'b1, -1, 8'h00, 4, -1, o, vc);
        bad = model_step(8'h85, 1'b1, vc);
        n_chk++; if (o.reg_wen_n + o.owt_wen_n + o.ren_n + o.owt_ren_n !== 0) $display("FAIL crc_strobes got %0d want 0", o.reg_wen_n + o.owt_wen_n + o.ren_n + o.owt_ren_n); else n_pass++;
        n_chk++; if (o.err !== 1'b1 || !bad) $display("FAIL crc_err got %b want 1", o.err); else n_pass++;
`ifdef SPI_ERR_CNT_EN
        n_chk++; if (o.cnt !== 8'd1) $display("FAIL crc_cnt got %0d want 1", o.cnt); else n_pass++;
`endif
    endtask

    task automatic test_gap_edge();
        obs_t o;
        int vc;
        int base;
        bit bad;
        base = last_cyc;
        wait_to(base + 98);
        run_frame(8'h70, 8'h00, 1'b0, -1, 8'h00, 4, -1, o, vc);
        bad = model_step(8'h70, 1'b0, vc);
        n_chk++; if (o.owt_ren_n !== 0 || o.err !== 1'b1) $display("FAIL gap98 got %0d/%b want 0/1", o.owt_ren_n, o.err); else n_pass++;
        wait_to(base + 102);
        run_frame(8'h70, 8'h00, 1'b0, -1, 8'h00, 5, -1, o, vc);
        bad = model_step(8'h70, 1'b0, vc);
        n_chk++; if (o.owt_ren_n !== 1 || o.owt_addr !== 7'h70) $display("FAIL gap102 got %0d/%h want 1/70", o.owt_ren_n, o.owt_addr); else n_pass++;
        n_chk++; if (o.tx_n !== 1 || o.tx_data !== 8'h00) $display("FAIL owt_rd_tx got %0d/%h want 1/00", o.tx_n, o.tx_data); else n_pass++;
        n_chk++; if (o.err !== 1'b0) $display("FAIL gap102_err got %b want 0", o.err); else n_pass++;
    endtask

    task automatic test_drop();
        obs_t o;
        int vc;
        bit bad;
        wait_to(prev_vld + 30);
        run_frame(8'h05, 8'h00, 1'b0, 6, 8'h5A, 12, 4, o, vc);
        bad = model_step(8'h05, 1'b0, vc);
        n_chk++; if (o.ren_n !== 7 || o.tx_data !== 8'h5A) $display("FAIL drop_rd got %0d/%h want 7/5a", o.ren_n, o.tx_data); else n_pass++;
        n_chk++; if (o.reg_wen_n !== 0 || o.err !== 1'b1) $display("FAIL drop_err got %0d/%b want 0/1", o.reg_wen_n, o.err); else n_pass++;
`ifdef SPI_ERR_CNT_EN
        n_chk++; if (o.cnt !== 8'd1) $display("FAIL drop_cnt got %0d want 1", o.cnt); else n_pass++;
`endif
    endtask

    task automatic test_random();
        obs_t o;
        int vc, dly, d, ren_x;
        logic [7:0] cmd, data, rdata, tx_x;
        logic crc;
        bit bad, wr, owt, ack, err_x;
        for (int i = 0; i < 40; i++) begin
            cmd = 8'($urandom);
            case ($urandom_range(0, 3))
                0: cmd[6:0] = 7'h5F;
                1: cmd[6:0] = 7'h60;
                default: ;
            endcase
            data  = 8'($urandom);
            rdata = 8'($urandom);
            crc   = ($urandom_range(0, 7) == 0);
            dly   = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 14));
            d     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 90))
                                                : int'($urandom_range(110, 200));
            wait_to(prev_vld + d);
            run_frame(cmd, data, crc, dly, rdata, 20, -1, o, vc);
            bad   = model_step(cmd, crc, vc);
            wr    = cmd[7];
            owt   = (cmd[6:0] >= 7'h60);
            ack   = (dly >= 1) && (dly <= RACK_TO - 1);
            ren_x = (!bad && !wr && !owt) ? (ack ? dly + 1 : RACK_TO) : 0;
            tx_x  = owt ? 8'h00 : (ack ? rdata : 8'hFF);
            err_x = bad || (ren_x != 0 && !ack);
            n_chk++; if (o.reg_wen_n !== int'(!bad && wr && !owt)) $display("FAIL rnd%0d_reg_wen got %0d cmd %h", i, o.reg_wen_n, cmd); else n_pass++;
            n_chk++; if (o.owt_wen_n !== int'(!bad && wr && owt)) $display("FAIL rnd%0d_owt_wen got %0d cmd %h", i, o.owt_wen_n, cmd); else n_pass++;
            n_chk++; if (o.owt_ren_n !== int'(!bad && !wr && owt)) $display("FAIL rnd%0d_owt_ren got %0d cmd %h", i, o.owt_ren_n, cmd); else n_pass++;
            n_chk++; if (o.ren_n !== ren_x) $display("FAIL rnd%0d_ren got %0d want %0d", i, o.ren_n, ren_x); else n_pass++;
            n_chk++; if (o.err !== err_x) $display("FAIL rnd%0d_err got %b want %b", i, o.err, err_x); else n_pass++;
`ifdef SPI_ERR_CNT_EN
            n_chk++; if (o.cnt !== 8'(err_x)) $display("FAIL rnd%0d_cnt got %0d want %0d", i, o.cnt, err_x); else n_pass++;
`endif
            if (!bad && !wr) begin
                n_chk++; if (o.tx_n !== 1 || o.tx_data !== tx_x) $display("FAIL rnd%0d_tx got %0d/%h want 1/%h", i, o.tx_n, o.tx_data, tx_x); else n_pass++;
            end
            if (!bad && wr && !owt) begin
                n_chk++; if (o.reg_wen_k !== 2 || o.reg_addr !== cmd[6:0] || o.reg_wdata !== data) $display("FAIL rnd%0d_reg_bus got %0d %h/%h want 2 %h/%h", i, o.reg_wen_k, o.reg_addr, o.reg_wdata, cmd[6:0], data); else n_pass++;
            end
            if (!bad && wr && owt) begin
                n_chk++; if (o.owt_addr !== cmd[6:0] || o.owt_wdata !== data) $display("FAIL rnd%0d_owt_bus got %h/%h want %h/%h", i, o.owt_addr, o.owt_wdata, cmd[6:0], data); else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        int vc;
        bit bad;
        wait_to(prev_vld + 150);
        run_frame(8'h05, 8'h00, 1'b0, -1, 8'h00, 6, -1, o, vc);
        bad = model_step(8'h05, 1'b0, vc);
        n_chk++; if (o.ren_n !== 4 || reg_ren !== 1'b1) $display("FAIL arst_pre got %0d/%b want 4/1", o.ren_n, reg_ren); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({reg_ren, reg_wen, owt_wen, owt_ren, tx_vld} !== 5'b0) $display("FAIL arst_drop got %b want 00000", {reg_ren, reg_wen, owt_wen, owt_ren, tx_vld}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        last_acc = 0;
        run_frame(8'h85, 8'hC3, 1'b0, -1, 8'h00, 4, -1, o, vc);
        bad = model_step(8'h85, 1'b0, vc);
        n_chk++; if (o.reg_wen_n !== 1 || o.reg_wdata !== 8'hC3 || o.err !== 1'b0) $display("FAIL arst_post got %0d/%h/%b want 1/c3/0", o.reg_wen_n, o.reg_wdata, o.err); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_gap();
        test_timeout();
        test_owt();
        test_crc();
        test_gap_edge();
        test_drop();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
